// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache with tree-PLRU replacement, whole-cache flush and hit/miss counters.
// Latency: hit 2 cycles, miss 2 cycles + memory; flush num_sets cycles; the CPU holds mem_read until the mem_resp pulse.
module icache_nway #(
    parameter int s_offset = 5,
    parameter int s_index  = 5,
    parameter int s_tag    = 32 - s_offset - s_index,
    parameter int s_line   = 8 * 2**s_offset,
    parameter int num_ways = 2,
    parameter int s_cnt    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic [31:0]       mem_address,
    output logic [s_line-1:0] mem_rdata256,
    output logic              mem_resp,
    output logic              pmem_read,
    output logic [31:0]       pmem_address,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp,
    input  logic              flush,
    output logic              flush_done,
    output logic              busy,
    output logic [s_cnt-1:0]  hit_count,
    output logic [s_cnt-1:0]  miss_count
);
    localparam int num_sets = 2**s_index;
    localparam int lvl      = $clog2(num_ways);

    typedef enum logic [1:0] {IDLE, TAG_CHECK, FILL, FLUSH} state_t;

    state_t              state;
    logic [s_tag-1:0]    tag_arr  [num_ways][num_sets];
    logic [s_line-1:0]   data_arr [num_ways][num_sets];
    logic [num_sets-1:0] valid_arr [num_ways];
    logic [num_ways-2:0] plru_arr [num_sets];

    logic [s_tag-1:0]    rd_tag  [num_ways];
    logic [s_line-1:0]   rd_data [num_ways];
    logic [num_ways-1:0] rd_vld;

    logic [s_tag-1:0]    a_tag, req_tag;
    logic [s_index-1:0]  a_idx, req_idx, flush_idx;
    logic [lvl-1:0]      victim_q, victim, hit_way, inv_way;
    logic                hit, inv, flush_pending;
    logic                unused_offset;

    assign a_tag         = mem_address[31 -: s_tag];
    assign a_idx         = mem_address[s_offset +: s_index];
    assign unused_offset = ^mem_address[s_offset-1:0];

    // Tree walk: PLRU bit 0 sends the victim search to the lower half of that subtree.
    function automatic logic [lvl-1:0] plru_victim(input logic [num_ways-2:0] bits);
        int                  node;
        logic [num_ways-2:0] sh;
        node = 1;
        for (int l = 0; l < lvl; l++) begin
            sh   = bits >> (node - 1);
            node = 2 * node + int'(sh[0]);
        end
        return lvl'(node - num_ways);
    endfunction

    // Point every node on the path to way away from it, making way most-recent.
    function automatic logic [num_ways-2:0] plru_touch(input logic [num_ways-2:0] bits,
                                                        input logic [lvl-1:0] way);
        int                  node;
        logic [lvl-1:0]      t;
        logic [num_ways-2:0] one, mask, res;
        node = 1;
        res  = bits;
        one  = '0;
        one[0] = 1'b1;
        for (int l = 0; l < lvl; l++) begin
            t    = way >> (lvl - 1 - l);
            mask = one << (node - 1);
            res  = t[0] ? (res & ~mask) : (res | mask);
            node = 2 * node + int'(t[0]);
        end
        return res;
    endfunction

    // Downward scans so the lowest-numbered way wins both searches.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        inv     = 1'b0;
        inv_way = '0;
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (rd_vld[w] && rd_tag[w] == req_tag) begin
                hit     = 1'b1;
                hit_way = lvl'(w);
            end
            if (!rd_vld[w]) begin
                inv     = 1'b1;
                inv_way = lvl'(w);
            end
        end
        victim = inv ? inv_way : plru_victim(plru_arr[req_idx]);
    end

    // Tag/data storage is not reset; every array read is registered, addressed by the live request index.
    always_ff @(posedge clk) begin
        for (int w = 0; w < num_ways; w++) begin
            rd_tag[w]  <= tag_arr[w][a_idx];
            rd_data[w] <= data_arr[w][a_idx];
            rd_vld[w]  <= valid_arr[w][a_idx];
        end
        if (state == FILL && pmem_resp) begin
            tag_arr[victim_q][req_idx]  <= req_tag;
            data_arr[victim_q][req_idx] <= pmem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            for (int w = 0; w < num_ways; w++) valid_arr[w] <= '0;
            for (int s = 0; s < num_sets; s++) plru_arr[s] <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
            flush_pending <= 1'b0;
            mem_resp      <= 1'b0;
            mem_rdata256  <= '0;
            pmem_read     <= 1'b0;
            pmem_address  <= '0;
            flush_done    <= 1'b0;
            busy          <= 1'b0;
            req_tag       <= '0;
            req_idx       <= '0;
            victim_q      <= '0;
            flush_idx     <= '0;
        end else begin
            mem_resp   <= 1'b0;
            flush_done <= 1'b0;
            if (flush && state != IDLE) flush_pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (flush || flush_pending) begin
                        state     <= FLUSH;
                        busy      <= 1'b1;
                        flush_idx <= '0;
                    end else if (mem_read && !mem_resp) begin
                        // The response cycle still sees the finished request's mem_read; it must not restart it.
                        state   <= TAG_CHECK;
                        busy    <= 1'b1;
                        req_tag <= a_tag;
                        req_idx <= a_idx;
                    end
                end
                TAG_CHECK: begin
                    if (hit) begin
                        mem_resp          <= 1'b1;
                        mem_rdata256      <= rd_data[hit_way];
                        plru_arr[req_idx] <= plru_touch(plru_arr[req_idx], hit_way);
                        hit_count         <= hit_count + 1'b1;
                        state             <= IDLE;
                        busy              <= 1'b0;
                    end else begin
                        miss_count   <= miss_count + 1'b1;
                        victim_q     <= victim;
                        pmem_read    <= 1'b1;
                        pmem_address <= {req_tag, req_idx, {s_offset{1'b0}}};
                        state        <= FILL;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        valid_arr[victim_q][req_idx] <= 1'b1;
                        plru_arr[req_idx]            <= plru_touch(plru_arr[req_idx], victim_q);
                        mem_resp                     <= 1'b1;
                        mem_rdata256                 <= pmem_rdata;
                        pmem_read                    <= 1'b0;
                        state                        <= IDLE;
                        busy                         <= 1'b0;
                    end
                end
                FLUSH: begin
                    for (int w = 0; w < num_ways; w++) valid_arr[w][flush_idx] <= 1'b0;
                    plru_arr[flush_idx] <= '0;
                    flush_idx           <= flush_idx + 1'b1;
                    // flush_done is registered, so it is raised one set early to land on the final flush cycle.
                    flush_done          <= (flush_idx == s_index'(num_sets - 2));
                    if (flush_idx == s_index'(num_sets - 1)) begin
                        state         <= IDLE;
                        busy          <= 1'b0;
                        flush_done    <= 1'b0;
                        flush_pending <= flush;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_nway.sv
// Randomised and directed bench for icache_nway (4-way) against a set/way/tree-PLRU reference model.
module tb_icache_nway;
    localparam int NW = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         mem_read = 1'b0;
    logic [31:0]  mem_address = '0;
    logic [255:0] mem_rdata256;
    logic         mem_resp;
    logic         pmem_read;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
    logic         flush = 1'b0;
    logic         flush_done;
    logic         busy;
    logic [31:0]  hit_count, miss_count;

    always #5 clk = ~clk;

    icache_nway #(.num_ways(NW)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_address(mem_address),
        .mem_rdata256(mem_rdata256), .mem_resp(mem_resp), .pmem_read(pmem_read),
        .pmem_address(pmem_address), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .flush(flush), .flush_done(flush_done), .busy(busy),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    int nchk = 0;
    int nfail = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Backing memory: each line holds a distinct pattern; line 0x40 is all A5.
    function automatic logic [255:0] memline(input logic [31:0] la);
        return {8{32'hA5A5A5A5 ^ la ^ 32'h40}};
    endfunction

    // Reference model: line address per (set, way), valid, and a binary tree keyed by
    // the split point of each way range (m_right=1: least-recent side is the upper half).
    logic [31:0] m_line  [32][NW];
    bit          m_val   [32][NW];
    bit          m_right [32][NW];
    int          m_hits, m_misses;

    task automatic m_flush();
        for (int s = 0; s < 32; s++)
            for (int w = 0; w < NW; w++) begin
                m_val[s][w]   = 0;
                m_right[s][w] = 0;
            end
    endtask

    task automatic m_reset();
        m_flush();
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic m_touch(input int s, input int w);
        int lo = 0, hi = NW, mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (w >= mid) begin m_right[s][mid] = 0; lo = mid; end
            else          begin m_right[s][mid] = 1; hi = mid; end
        end
    endtask

    function automatic int m_victim(input int s);
        int lo = 0, hi = NW, mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (m_right[s][mid]) lo = mid; else hi = mid;
        end
        return lo;
    endfunction

    task automatic m_access(input logic [31:0] a, output bit hit);
        int s = int'(a[9:5]);
        logic [31:0] la = {a[31:5], 5'b0};
        int w = -1;
        for (int i = NW - 1; i >= 0; i--) if (m_val[s][i] && m_line[s][i] == la) w = i;
        hit = (w >= 0);
        if (!hit) begin
            for (int i = NW - 1; i >= 0; i--) if (!m_val[s][i]) w = i;
            if (w < 0) w = m_victim(s);
            m_val[s][w]  = 1;
            m_line[s][w] = la;
            m_misses++;
        end else begin
            m_hits++;
        end
        m_touch(s, w);
    endtask

    // One CPU read with a memory responder; optionally pulses flush alongside the read or during the fill.
    task automatic access(input logic [31:0] a, input bit flush_with, input bit flush_mid,
                          output bit saw_pmem, output int lat, output bit saw_done,
                          output logic [255:0] dat, output logic [31:0] pm_addr);
        bit issued = 0, done = 0;
        int wait_cnt = -1;
        saw_pmem = 0; lat = 0; saw_done = 0; dat = '0; pm_addr = '0;
        @(posedge clk); #1;
        mem_read = 1'b1;
        mem_address = a;
        flush = flush_with;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            flush = 1'b0;
            pmem_resp = 1'b0;
            lat++;
            if (flush_done) saw_done = 1;
            if (mem_resp) begin
                dat = mem_rdata256;
                done = 1;
                break;
            end
            if (pmem_read && !issued) begin
                issued = 1;
                saw_pmem = 1;
                pm_addr = pmem_address;
                wait_cnt = int'($urandom_range(0, 3));
                if (flush_mid) flush = 1'b1;
            end
            if (issued && wait_cnt >= 0) begin
                if (wait_cnt == 0) begin
                    pmem_resp = 1'b1;
                    pmem_rdata = memline(pm_addr);
                    wait_cnt = -1;
                end else begin
                    wait_cnt--;
                end
            end
        end
        mem_read = 1'b0;
        check("access_completes", 256'(done), 256'(1));
    endtask

    // Access checked against the model; returns the observed hit/miss.
    task automatic run_access(input logic [31:0] a, input bit flush_with, input bit flush_mid,
                              output bit obs_hit);
        bit exp_hit, saw_pmem, saw_done;
        int lat;
        logic [255:0] dat;
        logic [31:0] pm;
        logic [31:0] la = {a[31:5], 5'b0};
        if (flush_with) m_flush();
        m_access(a, exp_hit);
        if (flush_mid) m_flush();
        access(a, flush_with, flush_mid, saw_pmem, lat, saw_done, dat, pm);
        obs_hit = !saw_pmem;
        check("hit_vs_model", 256'(obs_hit), 256'(exp_hit));
        check("rdata", dat, memline(la));
        if (!exp_hit) check("pmem_address", 256'(pm), 256'(la));
        if (exp_hit && !flush_with) check("hit_latency", 256'(lat), 256'(2));
        if (flush_with) check("flush_before_read_done", 256'(saw_done), 256'(1));
        check("hit_count", 256'(hit_count), 256'(m_hits));
        check("miss_count", 256'(miss_count), 256'(m_misses));
    endtask

    // Samples from the current cycle until busy drops.
    task automatic flush_watch(output int busy_cnt, output int done_at, output int ndone);
        busy_cnt = 0; done_at = -1; ndone = 0;
        for (int c = 0; c < 60; c++) begin
            if (flush_done) begin done_at = busy_cnt + 1; ndone++; end
            if (busy) busy_cnt++;
            else break;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bit h;
        int bc, da, nd;
        logic [31:0] a;

        m_reset();
        #1;
        check("rst_mem_resp", 256'(mem_resp), 256'(0));
        check("rst_pmem_read", 256'(pmem_read), 256'(0));
        check("rst_pmem_address", 256'(pmem_address), 256'(0));
        check("rst_rdata", mem_rdata256, 256'(0));
        check("rst_busy_done", 256'({busy, flush_done}), 256'(0));
        check("rst_counters", 256'({hit_count, miss_count}), 256'(0));
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        run_access(32'h0000_0044, 0, 0, h);
        check("first_read_miss", 256'(h), 256'(0));
        check("first_read_line", mem_rdata256, {32{8'hA5}});
        run_access(32'h0000_0040, 0, 0, h);
        check("reread_hit", 256'(h), 256'(1));

        // Set 0: A..D fill four ways, A refreshed, E must evict C.
        run_access(32'h0000_0000, 0, 0, h);
        run_access(32'h0000_0400, 0, 0, h);
        run_access(32'h0000_0800, 0, 0, h);
        run_access(32'h0000_0C00, 0, 0, h);
        run_access(32'h0000_0000, 0, 0, h);
        check("plru_A_hit", 256'(h), 256'(1));
        run_access(32'h0000_1000, 0, 0, h);
        run_access(32'h0000_0000, 0, 0, h);
        check("plru_A_kept", 256'(h), 256'(1));
        run_access(32'h0000_0400, 0, 0, h);
        check("plru_B_kept", 256'(h), 256'(1));
        run_access(32'h0000_0800, 0, 0, h);
        check("plru_C_evicted", 256'(h), 256'(0));

        for (int i = 0; i < 150; i++) begin
            a = {19'($urandom_range(0, 7)), 3'b000, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31))};
            run_access(a, 0, 0, h);
        end

        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        flush_watch(bc, da, nd);
        m_flush();
        check("flush_busy_cycles", 256'(bc), 256'(32));
        check("flush_done_cycle", 256'(da), 256'(32));
        check("flush_done_pulses", 256'(nd), 256'(1));
        run_access(32'h0000_0040, 0, 0, h);
        check("after_flush_miss", 256'(h), 256'(0));
        run_access(32'h0000_0000, 0, 0, h);
        check("after_flush_miss2", 256'(h), 256'(0));

        run_access(32'h0000_2060, 0, 1, h);
        @(posedge clk); #1;
        check("flush_after_fill_starts", 256'(busy), 256'(1));
        flush_watch(bc, da, nd);
        check("pending_flush_cycles", 256'(bc), 256'(32));
        check("pending_flush_done", 256'(da), 256'(32));

        run_access(32'h0000_0040, 1, 0, h);
        check("flush_with_read_miss", 256'(h), 256'(0));

        @(posedge clk); #1;
        mem_read = 1'b1;
        mem_address = 32'h0000_3080;
        for (int c = 0; c < 10 && !pmem_read; c++) begin @(posedge clk); #1; end
        check("fill_requested", 256'(pmem_read), 256'(1));
        #2;
        rst = 1'b0;
        #1;
        mem_read = 1'b0;
        m_reset();
        check("rst_mid_fill_pmem_read", 256'(pmem_read), 256'(0));
        check("rst_mid_fill_busy", 256'(busy), 256'(0));
        check("rst_mid_fill_counters", 256'({hit_count, miss_count}), 256'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b1;
        pmem_rdata = memline(32'h0000_3080);
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        check("stray_pmem_resp_resp", 256'({mem_resp, busy}), 256'(0));
        @(posedge clk); #1;
        check("stray_pmem_resp_idle", 256'({mem_resp, busy}), 256'(0));
        run_access(32'h0000_3080, 0, 0, h);
        check("after_reset_miss", 256'(h), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/icache_nway.md
Name: icache_nway

Overview:
- Parametrised N-way set-associative, read-only instruction cache. It is the successor to the fixed 2-way icache datapath/control pair, with tag/data/valid/PLRU storage and the controller merged into one block.
- Sits between the CPU fetch bus adapter (256-bit line interface) and physical memory (line-fill interface).
- Adds:
  - configurable way count, with tree pseudo-LRU replacement;
  - whole-cache invalidate (flush);
  - hit and miss counters.

Parameters:
- s_offset, 5, line offset bits; line = 2**s_offset bytes.
- s_index, 5, set index bits; num_sets = 2**s_index.
- s_tag, 32-s_offset-s_index, tag bits.
- s_line, 8*2**s_offset, line width in bits (256 default).
- num_ways, 2, associativity; power of two, 2..8.
- s_cnt, 32, width of the hit/miss counters.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted at 0).
- mem_read  input  1  CPU read request; held high with a stable mem_address until mem_resp.
- mem_address  input  32  CPU byte address.
- mem_rdata256  output  s_line  line returned to the CPU; valid when mem_resp=1.
- mem_resp  output  1  one-cycle completion pulse to the CPU.
- pmem_read  input→output  1  line-fill request to memory; held until pmem_resp.
- pmem_address  output  32  line-aligned fill address.
- pmem_rdata  input  s_line  fill data; valid with pmem_resp.
- pmem_resp  input  1  memory completion pulse.
- flush  input  1  single-cycle pulse requesting invalidation of every line.
- flush_done  output  1  one-cycle pulse when invalidation completes.
- busy  output  1  high in any state other than IDLE.
- hit_count  output  s_cnt  number of hits since reset.
- miss_count  output  s_cnt  number of misses since reset.

(pmem_read is an output.)

Behaviour:
- Address split:
  - tag = mem_address[31:s_offset+s_index];
  - index = mem_address[s_offset+s_index-1:s_offset];
  - offset bits are ignored; the full line is always returned.
- Storage:
  - per way: tag, data and valid arrays of num_sets entries;
  - per set: num_ways-1 tree-PLRU bits;
  - arrays are read synchronously, addressed by the index of mem_address.
- Reset (async, rst=0):
  - state=IDLE;
  - all valid bits=0, all PLRU bits=0, hit_count=0, miss_count=0, flush_pending=0;
  - mem_resp=0, pmem_read=0, pmem_address=0, mem_rdata256=0, flush_done=0, busy=0;
  - tag and data arrays are not reset.
- FSM states: IDLE, TAG_CHECK, FILL, FLUSH.
  - IDLE:
    - flush or flush_pending → FLUSH, set counter=0 (flush wins over a simultaneous mem_read);
    - else mem_read → TAG_CHECK.
  - TAG_CHECK:
    - hit on way w (valid & tag match): mem_resp=1, mem_rdata256=data[w], PLRU updated to mark w most-recent, hit_count+1 → IDLE.
    - miss: miss_count+1, victim latched → FILL.
    - Victim = lowest-numbered invalid way; if all ways are valid, the PLRU-selected way.
    - More than one way matching is impossible by construction; priority goes to the lowest way.
  - FILL:
    - pmem_read=1 and pmem_address={tag,index,s_offset'b0}, both stable until pmem_resp.
    - On pmem_resp: victim data←pmem_rdata, tag←tag, valid←1; PLRU marks victim most-recent; mem_resp=1 with mem_rdata256=pmem_rdata (bypass) → IDLE.
  - FLUSH:
    - clears valid for all ways of one set per cycle, counter 0..num_sets-1;
    - on the last set: flush_done=1, flush_pending←0 → IDLE;
    - takes exactly num_sets cycles; PLRU bits are also cleared.
- Flush arriving outside IDLE: latched in flush_pending. The current access completes normally, then FLUSH begins.
- Hit latency: 2 cycles, mem_read sampled in IDLE → mem_resp in TAG_CHECK.
- Miss latency: 2 cycles + memory latency.
- mem_resp is always a single cycle. In the cycle after mem_resp the FSM is in IDLE, and a still-high mem_read starts a new access.
- mem_read deasserted mid-FILL: the fill completes, the line is installed, and mem_resp still pulses.
- pmem_resp outside FILL is ignored.
- Counters wrap modulo 2**s_cnt and never saturate.
- Reset mid-FILL: pmem_read drops asynchronously, and the partially requested line is not installed.

Test Plan:
- Reset, then read 0x0000_0044 → pmem_read=1, pmem_address=0x0000_0040; drive pmem_resp with line 0xA5..A5 → mem_resp one cycle, mem_rdata256=0xA5..A5, miss_count=1.
- Re-read 0x0000_0040 → mem_resp exactly 2 cycles after mem_read, no pmem_read, data 0xA5..A5, hit_count=1.
- num_ways=2: fill 0x0000, 0x0400, then re-read 0x0000, then fill 0x0800 (all set 0) → 0x0800 evicts 0x0400's way; then 0x0000 hits and 0x0400 misses. Repeat with num_ways=4 using 5 conflicting lines and a PLRU reference model.
- Fill 3 sets, pulse flush → busy for 32 cycles, flush_done pulses on the 32nd; every re-read then misses.
- Pulse flush while in FILL → fill completes with mem_resp, then FLUSH starts in the next cycle; flush in the same cycle as mem_read in IDLE → FLUSH first, then the read is serviced.
- Assert rst=0 mid-FILL → pmem_read=0 immediately and counters=0; a later pmem_resp in IDLE is ignored; re-reading the same address misses.
